// File: rtl/pipe_pkg.sv
// pipe_pkg: types and constants shared by the pipeline hazard logic and the
// datapath forwarding muxes.
//   PIPE_REG_AW  register-address width of the scoreboard entries
//   sb_entry_t   one in-flight instruction: {v, we, dst, ld}
//   FWD_*        ALU operand source encodings (RF / MEM ALU result / WB data)
//   fwd_pick     operand source choice from the EX and MEM entry matches
package pipe_pkg;

  localparam int PIPE_REG_AW = 5;

  // ALU operand source selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // Scoreboard entry for one pipeline stage
  typedef struct packed {
    logic                   v;    // stage holds a real instruction
    logic                   we;   // instruction writes the RF
    logic [PIPE_REG_AW-1:0] dst;  // destination register
    logic                   ld;   // instruction is a load
  } sb_entry_t;

  // The producer in EX moves to MEM and wins over the one in MEM (which moves
  // to WB) because it is younger. A load in EX is never forwarded from MEM:
  // a consumer that reads it is stalled instead, so its value comes from WB.
  function automatic logic [1:0] fwd_pick(input logic hit_ex,
                                          input logic ex_is_ld,
                                          input logic hit_mem);
    logic [1:0] sel;
    if (hit_ex && !ex_is_ld) begin
      sel = FWD_MEM;
    end else if (hit_mem) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_cmp.sv
// hazard_cmp: compares one source register against one scoreboard entry.
//   src_i    source register read by the ID instruction
//   ent_i    scoreboard entry of a later stage
//   match_o  entry is a valid RF writer of src_i; $0 never matches
module hazard_cmp
  import pipe_pkg::*;
(
  input  logic [PIPE_REG_AW-1:0] src_i,
  input  sb_entry_t              ent_i,
  output logic                   match_o
);

  // The load flag is irrelevant to the match itself; the caller qualifies it.
  logic unused_ld;
  assign unused_ld = ent_i.ld;

  assign match_o = ent_i.v & ent_i.we & (ent_i.dst == src_i) &
                   (src_i != {PIPE_REG_AW{1'b0}});

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard / stall / flush controller for the 5-stage MIPS pipeline.
// Keeps a scoreboard of the instructions in EX and MEM, raises PC / IF-ID hold,
// IF-ID flush and ID-EX bubble, and produces registered ALU forwarding selects.
//
// Build option: define HAZARD_FORWARDING_EN to enable operand forwarding. Then
// only a load-use dependency stalls (one cycle). Without it any RAW dependency
// on EX or MEM stalls until the producer reaches WB and the selects stay 00.
//
// Ports
//   CLK, RST        clock, synchronous active-high reset
//   id_*            decode-stage instruction info (valid, rs/rt + use, dst, we, load)
//   ex_redirect     taken branch / jump resolved in EX
//   stall_pc        hold PC                  (comb)
//   stall_ifid      hold IF/ID               (comb)
//   flush_ifid      clear IF/ID              (comb)
//   bubble_idex     load a NOP into ID/EX    (comb)
//   fwd_a_sel/b     ALU operand sources for the EX instruction (reg)
//   stall_cnt       saturating count of stall cycles
//   flush_cnt       saturating count of redirect flushes
//
// The WB stage needs no scoreboard entry here: the RF is written in the first
// half-cycle, so a WB producer is never a hazard, and the WB (10) select is
// latched from the MEM entry on the edge where that producer moves into WB.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW = PIPE_REG_AW,  // must equal PIPE_REG_AW (scoreboard dst width)
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_rf_we,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_is_load,
  input  logic              ex_redirect,
  output logic              stall_pc,
  output logic              stall_ifid,
  output logic              flush_ifid,
  output logic              bubble_idex,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  sb_entry_t        ex_q, mem_q;
  sb_entry_t        ex_d;
  logic [1:0]       fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic m_rs_ex, m_rs_mem, m_rt_ex, m_rt_mem;
  logic h_rs, h_rt, haz;
  logic do_flush, do_stall;

  hazard_cmp u_cmp_rs_ex  (.src_i(id_rs), .ent_i(ex_q),  .match_o(m_rs_ex));
  hazard_cmp u_cmp_rs_mem (.src_i(id_rs), .ent_i(mem_q), .match_o(m_rs_mem));
  hazard_cmp u_cmp_rt_ex  (.src_i(id_rt), .ent_i(ex_q),  .match_o(m_rt_ex));
  hazard_cmp u_cmp_rt_mem (.src_i(id_rt), .ent_i(mem_q), .match_o(m_rt_mem));

  // Hazard detection and stall/flush decisions; redirect beats a hazard
  always_comb begin
    h_rs = 1'b0;
    h_rt = 1'b0;
`ifdef HAZARD_FORWARDING_EN
    // Only a load in EX cannot be forwarded in time.
    h_rs = m_rs_ex & ex_q.ld;
    h_rt = m_rt_ex & ex_q.ld;
`else
    h_rs = m_rs_ex | m_rs_mem;
    h_rt = m_rt_ex | m_rt_mem;
`endif
    haz = id_valid & ((id_use_rs & h_rs) | (id_use_rt & h_rt));
    if (RST) begin
      do_flush = 1'b0;
      do_stall = 1'b0;
    end else if (ex_redirect) begin
      do_flush = 1'b1;
      do_stall = 1'b0;
    end else begin
      do_flush = 1'b0;
      do_stall = haz;
    end
    stall_pc    = do_stall;
    stall_ifid  = do_stall;
    flush_ifid  = do_flush;
    bubble_idex = do_stall | do_flush;
  end

  // Next scoreboard EX entry and next forwarding selects
  always_comb begin
    ex_d    = '0;
    fwd_a_d = FWD_RF;
    fwd_b_d = FWD_RF;
    if (bubble_idex) begin
      ex_d = '0;
    end else begin
      ex_d.v   = id_valid;
      ex_d.we  = id_rf_we;
      ex_d.dst = id_dst;
      ex_d.ld  = id_is_load;
`ifdef HAZARD_FORWARDING_EN
      fwd_a_d  = fwd_pick(m_rs_ex, ex_q.ld, m_rs_mem);
      fwd_b_d  = fwd_pick(m_rt_ex, ex_q.ld, m_rt_mem);
`else
      fwd_a_d  = FWD_RF;
      fwd_b_d  = FWD_RF;
`endif
    end
  end

  // Saturating performance counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (do_stall && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (do_flush && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Scoreboard shift, forwarding-select and counter registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      ex_q        <= '0;
      mem_q       <= '0;
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      ex_q        <= ex_d;
      mem_q       <= ex_q;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RST, id_valid, id_use_rs, id_use_rt, id_rf_we, id_is_load, ex_redirect;
  logic [4:0] id_rs, id_rt, id_dst;

  logic        stall_pc, stall_ifid, flush_ifid, bubble_idex;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [15:0] stall_cnt, flush_cnt;
  logic        s_stall_pc, s_stall_ifid, s_flush_ifid, s_bubble_idex;
  logic [1:0]  s_fwd_a_sel, s_fwd_b_sel, s_stall_cnt, s_flush_cnt;

  hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rf_we(id_rf_we), .id_dst(id_dst),
    .id_is_load(id_is_load), .ex_redirect(ex_redirect),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .flush_ifid(flush_ifid),
    .bubble_idex(bubble_idex), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  hazard_ctrl #(.REG_AW(5), .CNT_W(2)) dut_sat (
    .CLK(CLK), .RST(RST), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rf_we(id_rf_we), .id_dst(id_dst),
    .id_is_load(id_is_load), .ex_redirect(ex_redirect),
    .stall_pc(s_stall_pc), .stall_ifid(s_stall_ifid), .flush_ifid(s_flush_ifid),
    .bubble_idex(s_bubble_idex), .fwd_a_sel(s_fwd_a_sel), .fwd_b_sel(s_fwd_b_sel),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt));

`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  int errs = 0;
  int checks = 0;

  // Reference model: list of in-flight instructions, youngest first
  // (index 0 = one ahead in EX, 1 = two ahead in MEM, 2 = in WB).
  typedef struct packed { logic v; logic we; logic [4:0] dst; logic ld; } ent_t;
  ent_t m_ent[$];
  int   m_sc, m_fc, m_scs, m_fcs;
  logic [1:0] m_fa, m_fb;

  // Observed values: comb outputs before the edge, registered after it
  logic [3:0]  obs_c, obs_cs, exp_c;   // {stall_pc, stall_ifid, flush_ifid, bubble_idex}
  logic [1:0]  obs_fa, obs_fb, obs_sfa, obs_sfb, obs_scs, obs_fcs;
  logic [15:0] obs_sc, obs_fc;

  function automatic bit writes(input logic [4:0] s, input int k);
    return m_ent[k].v && m_ent[k].we && (m_ent[k].dst == s) && (s != 5'd0);
  endfunction

  function automatic bit needs_stall(input logic [4:0] s);
    if (FWD) return writes(s, 0) && m_ent[0].ld;
    else     return writes(s, 0) || writes(s, 1);
  endfunction

  function automatic logic [1:0] src_of(input logic [4:0] s);
    if (!FWD) return 2'b00;
    if (writes(s, 0) && !m_ent[0].ld) return 2'b01;
    if (writes(s, 1)) return 2'b10;
    return 2'b00;
  endfunction

  // One clock cycle: drive at negedge, sample comb, advance model at posedge, sample regs
  task automatic step(input logic rst, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urs, input logic urt, input logic we, input logic [4:0] dst,
                      input logic ld, input logic redir);
    bit haz;
    logic [1:0] fa, fb;
    ent_t ne;
    RST = rst; id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_rf_we = we; id_dst = dst; id_is_load = ld; ex_redirect = redir;
    #1;
    obs_c  = {stall_pc, stall_ifid, flush_ifid, bubble_idex};
    obs_cs = {s_stall_pc, s_stall_ifid, s_flush_ifid, s_bubble_idex};
    haz = v && ((urs && needs_stall(rs)) || (urt && needs_stall(rt)));
    if (rst)        exp_c = 4'b0000;
    else if (redir) exp_c = 4'b0011;
    else if (haz)   exp_c = 4'b1101;
    else            exp_c = 4'b0000;
    fa = exp_c[0] ? 2'b00 : src_of(rs);
    fb = exp_c[0] ? 2'b00 : src_of(rt);
    @(posedge CLK);
    if (rst) begin
      m_ent = '{ent_t'(8'd0), ent_t'(8'd0), ent_t'(8'd0)};
      m_fa = 2'b00; m_fb = 2'b00; m_sc = 0; m_fc = 0; m_scs = 0; m_fcs = 0;
    end else begin
      m_fa = fa; m_fb = fb;
      ne.v = v; ne.we = we; ne.dst = dst; ne.ld = ld;
      m_ent.push_front(exp_c[0] ? ent_t'(8'd0) : ne);
      void'(m_ent.pop_back());
      if (redir) begin
        if (m_fc < 65535) m_fc++;
        if (m_fcs < 3) m_fcs++;
      end else if (haz) begin
        if (m_sc < 65535) m_sc++;
        if (m_scs < 3) m_scs++;
      end
    end
    #1;
    obs_fa = fwd_a_sel; obs_fb = fwd_b_sel; obs_sc = stall_cnt; obs_fc = flush_cnt;
    obs_sfa = s_fwd_a_sel; obs_sfb = s_fwd_b_sel; obs_scs = s_stall_cnt; obs_fcs = s_flush_cnt;
    @(negedge CLK);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (obs_c !== 4'b0000) begin errs++; $display("FAIL reset_comb got=%b exp=0000", obs_c); end
    checks++; if ({obs_fa, obs_fb} !== 4'b0000) begin errs++; $display("FAIL reset_fwd got=%b exp=0000", {obs_fa, obs_fb}); end
    checks++; if (obs_sc !== 16'd0 || obs_fc !== 16'd0) begin errs++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", obs_sc, obs_fc); end
  endtask

  // add $3,$1,$2 ; sub $4,$3,$5
  task automatic test_alu_dep();
    do_reset();
    step(1'b0, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
    checks++; if (obs_c !== 4'b0000) begin errs++; $display("FAIL alu_add_comb got=%b exp=0000", obs_c); end
    if (FWD) begin
      step(1'b0, 1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0);
      checks++; if (obs_c !== 4'b0000) begin errs++; $display("FAIL alu_sub_nostall got=%b exp=0000", obs_c); end
      checks++; if ({obs_fa, obs_fb} !== 4'b0100) begin errs++; $display("FAIL alu_fwd got=%b exp=0100", {obs_fa, obs_fb}); end
      checks++; if (obs_sc !== 16'd0) begin errs++; $display("FAIL alu_stall_cnt got=%0d exp=0", obs_sc); end
    end else begin
      for (int i = 0; i < 2; i++) begin
        step(1'b0, 1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0);
        checks++; if (obs_c !== 4'b1101) begin errs++; $display("FAIL alu_stall%0d got=%b exp=1101", i, obs_c); end
      end
      step(1'b0, 1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0);
      checks++; if (obs_c !== 4'b0000) begin errs++; $display("FAIL alu_release got=%b exp=0000", obs_c); end
      checks++; if ({obs_fa, obs_fb} !== 4'b0000) begin errs++; $display("FAIL alu_fwd got=%b exp=0000", {obs_fa, obs_fb}); end
      checks++; if (obs_sc !== 16'd2) begin errs++; $display("FAIL alu_stall_cnt got=%0d exp=2", obs_sc); end
    end
  endtask

  // lw $3,0($1) ; add $4,$3,$3
  task automatic test_load_use();
    do_reset();
    step(1'b0, 1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0);
    step(1'b0, 1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0);
    checks++; if (obs_c !== 4'b1101) begin errs++; $display("FAIL lu_stall got=%b exp=1101", obs_c); end
    checks++; if ({obs_fa, obs_fb} !== 4'b0000) begin errs++; $display("FAIL lu_bubble_fwd got=%b exp=0000", {obs_fa, obs_fb}); end
    if (!FWD) begin
      step(1'b0, 1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0);
      checks++; if (obs_c !== 4'b1101) begin errs++; $display("FAIL lu_stall2 got=%b exp=1101", obs_c); end
    end
    step(1'b0, 1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0);
    checks++; if (obs_c !== 4'b0000) begin errs++; $display("FAIL lu_release got=%b exp=0000", obs_c); end
    checks++; if ({obs_fa, obs_fb} !== (FWD ? 4'b1010 : 4'b0000)) begin errs++; $display("FAIL lu_fwd got=%b exp=%b", {obs_fa, obs_fb}, FWD ? 4'b1010 : 4'b0000); end
    checks++; if (obs_sc !== (FWD ? 16'd1 : 16'd2)) begin errs++; $display("FAIL lu_stall_cnt got=%0d exp=%0d", obs_sc, FWD ? 1 : 2); end
  endtask

  // addi $0,$0,5 ; add $2,$0,$0
  task automatic test_zero_reg();
    do_reset();
    step(1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0);
    checks++; if (obs_c !== 4'b0000) begin errs++; $display("FAIL r0_comb got=%b exp=0000", obs_c); end
    checks++; if ({obs_fa, obs_fb} !== 4'b0000) begin errs++; $display("FAIL r0_fwd got=%b exp=0000", {obs_fa, obs_fb}); end
    checks++; if (obs_sc !== 16'd0) begin errs++; $display("FAIL r0_stall_cnt got=%0d exp=0", obs_sc); end
  endtask

  // Load-use in ID while EX redirects: redirect wins
  task automatic test_redirect();
    do_reset();
    step(1'b0, 1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0);
    step(1'b0, 1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b1);
    checks++; if (obs_c !== 4'b0011) begin errs++; $display("FAIL redir_comb got=%b exp=0011", obs_c); end
    checks++; if (obs_fc !== 16'd1) begin errs++; $display("FAIL redir_flush_cnt got=%0d exp=1", obs_fc); end
    checks++; if (obs_sc !== 16'd0) begin errs++; $display("FAIL redir_stall_cnt got=%0d exp=0", obs_sc); end
  endtask

  // RST during a stall clears everything; next cycle nothing stalls
  task automatic test_reset_mid_stall();
    do_reset();
    step(1'b0, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, FWD, 1'b0);
    step(1'b0, 1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0);
    checks++; if (obs_c !== 4'b1101) begin errs++; $display("FAIL rms_stall got=%b exp=1101", obs_c); end
    step(1'b1, 1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0);
    checks++; if (obs_c !== 4'b0000) begin errs++; $display("FAIL rms_in_reset got=%b exp=0000", obs_c); end
    checks++; if ({obs_fa, obs_fb} !== 4'b0000 || obs_sc !== 16'd0 || obs_fc !== 16'd0) begin errs++; $display("FAIL rms_cleared got=%b/%0d/%0d exp=0000/0/0", {obs_fa, obs_fb}, obs_sc, obs_fc); end
    step(1'b0, 1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0);
    checks++; if (obs_c !== 4'b0000) begin errs++; $display("FAIL rms_after got=%b exp=0000", obs_c); end
  endtask

  // CNT_W=2 counters stop at 3
  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0);
      step(1'b0, 1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0);
      step(1'b0, 1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0);
    end
    checks++; if (obs_scs !== 2'd3) begin errs++; $display("FAIL sat_stall got=%0d exp=3", obs_scs); end
    checks++; if (obs_sc !== (FWD ? 16'd4 : 16'd8)) begin errs++; $display("FAIL sat_stall_wide got=%0d exp=%0d", obs_sc, FWD ? 4 : 8); end
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    checks++; if (obs_fcs !== 2'd3 || obs_fc !== 16'd5) begin errs++; $display("FAIL sat_flush got=%0d/%0d exp=3/5", obs_fcs, obs_fc); end
  endtask

  // Random instruction streams against the model
  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 59) == 0, $urandom_range(0, 7) != 0,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)),
           $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
      checks++; if (obs_c !== exp_c || obs_cs !== exp_c) begin errs++; $display("FAIL rnd_comb cyc=%0d got=%b/%b exp=%b", i, obs_c, obs_cs, exp_c); end
      checks++; if ({obs_fa, obs_fb} !== {m_fa, m_fb} || {obs_sfa, obs_sfb} !== {m_fa, m_fb}) begin errs++; $display("FAIL rnd_fwd cyc=%0d got=%b/%b exp=%b", i, {obs_fa, obs_fb}, {obs_sfa, obs_sfb}, {m_fa, m_fb}); end
      checks++; if (obs_sc !== 16'(m_sc) || obs_fc !== 16'(m_fc)) begin errs++; $display("FAIL rnd_cnt cyc=%0d got=%0d/%0d exp=%0d/%0d", i, obs_sc, obs_fc, m_sc, m_fc); end
      checks++; if (obs_scs !== 2'(m_scs) || obs_fcs !== 2'(m_fcs)) begin errs++; $display("FAIL rnd_sat cyc=%0d got=%0d/%0d exp=%0d/%0d", i, obs_scs, obs_fcs, m_scs, m_fcs); end
    end
  endtask

  initial begin
    m_ent = '{ent_t'(8'd0), ent_t'(8'd0), ent_t'(8'd0)};
    m_fa = 2'b00; m_fb = 2'b00; m_sc = 0; m_fc = 0; m_scs = 0; m_fcs = 0;
    RST = 1'b1; id_valid = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0;
    id_use_rt = 1'b0; id_rf_we = 1'b0; id_dst = 5'd0; id_is_load = 1'b0; ex_redirect = 1'b0;
    @(negedge CLK);
    test_reset();
    test_alu_dep();
    test_load_use();
    test_zero_reg();
    test_redirect();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
